// File: rtl/mux_pkg.sv
// Shared definitions for the select-indexed mux and its round-robin arbiter:
// channel-count helper and arbiter state encoding.
package mux_pkg;

  // Number of mux channels addressed by a select index of the given width.
  function automatic int calc_nch(input int sel_width);
    return 32'sd1 << sel_width;
  endfunction

  // Arbiter state: IDLE waits for any request, BUSY holds a grant until ack.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/rr_prio_find.sv
// Wrapping priority finder: returns the first set request bit at or after a
// start index, searching start, start+1, ... and wrapping past NCH-1 to 0.
// The request vector is doubled and shifted down by the start index so the
// search becomes a plain lowest-set-bit find on the rotated vector.
module rr_prio_find
  import mux_pkg::*;
#(
  parameter  int SEL_WIDTH = 4,
  localparam int NCH       = calc_nch(SEL_WIDTH)
) (
  input  logic [NCH-1:0]       req,
  input  logic [SEL_WIDTH-1:0] start,
  output logic                 found,
  output logic [SEL_WIDTH-1:0] idx
);

  logic [2*NCH-1:0]   dbl_s;
  logic [2*NCH-1:0]   shifted_s;
  logic [NCH-1:0]     rot_s;
  logic [SEL_WIDTH-1:0] off_s;

  assign dbl_s     = {req, req};
  assign shifted_s = dbl_s >> start;
  assign rot_s     = shifted_s[NCH-1:0];

  // Lowest set bit of the rotated vector; scanning downward lets the lowest win.
  always_comb begin
    off_s = {SEL_WIDTH{1'b0}};
    for (int i = NCH - 1; i >= 0; i--) begin
      off_s = rot_s[i] ? SEL_WIDTH'(i) : off_s;
    end
  end

  assign found = |rot_s;
  // Offset back into channel space; natural SEL_WIDTH-bit wrap does the modulo.
  assign idx   = start + off_s;

endmodule

// File: rtl/rr_sel_arb.sv
// Round-robin arbiter driving the select of the select-indexed mux.
// Holds each grant until the consumer acks, then rotates to the next
// requester after the one just served; all outputs come straight from flops.
module rr_sel_arb
  import mux_pkg::*;
#(
  parameter  int SEL_WIDTH = 4,
  localparam int NCH       = calc_nch(SEL_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       req_in,
  input  logic                 ack_in,
  output logic [SEL_WIDTH-1:0] sel_out,
  output logic [NCH-1:0]       gnt_out,
  output logic                 vld_out
);

  localparam logic [SEL_WIDTH-1:0] SEL_ONE  = SEL_WIDTH'(1);
  localparam logic [SEL_WIDTH-1:0] SEL_ZERO = {SEL_WIDTH{1'b0}};
  localparam logic [NCH-1:0]       NCH_ONE  = NCH'(1);
  localparam logic [NCH-1:0]       NCH_ZERO = {NCH{1'b0}};

  state_e               state_r, state_nxt_s;
  logic [SEL_WIDTH-1:0] ptr_r, ptr_nxt_s;
  logic [SEL_WIDTH-1:0] sel_r, sel_nxt_s;
  logic [NCH-1:0]       gnt_r, gnt_nxt_s;
  logic                 vld_r, vld_nxt_s;

  logic                 ack_busy_s;
  logic [SEL_WIDTH-1:0] after_sel_s;
  logic [SEL_WIDTH-1:0] start_s;
  logic                 found_s;
  logic [SEL_WIDTH-1:0] found_idx_s;

  assign ack_busy_s  = (state_r == ST_BUSY) && ack_in;
  assign after_sel_s = sel_r + SEL_ONE;
  // On an ack the just-served channel becomes lowest priority; otherwise
  // the search starts from the rotation pointer.
  assign start_s     = ack_busy_s ? after_sel_s : ptr_r;

  rr_prio_find #(
    .SEL_WIDTH (SEL_WIDTH)
  ) u_find (
    .req   (req_in),
    .start (start_s),
    .found (found_s),
    .idx   (found_idx_s)
  );

  // Next-state and next-output decode; grants are sticky until acknowledged.
  always_comb begin
    state_nxt_s = state_r;
    ptr_nxt_s   = ptr_r;
    sel_nxt_s   = sel_r;
    gnt_nxt_s   = gnt_r;
    vld_nxt_s   = vld_r;
    case (state_r)
      ST_IDLE: begin
        if (found_s) begin
          state_nxt_s = ST_BUSY;
          sel_nxt_s   = found_idx_s;
          gnt_nxt_s   = NCH_ONE << found_idx_s;
          vld_nxt_s   = 1'b1;
        end else begin
          gnt_nxt_s   = NCH_ZERO;
          vld_nxt_s   = 1'b0;
        end
      end
      ST_BUSY: begin
        if (ack_in) begin
          ptr_nxt_s = after_sel_s;
          if (found_s) begin
            sel_nxt_s = found_idx_s;
            gnt_nxt_s = NCH_ONE << found_idx_s;
            vld_nxt_s = 1'b1;
          end else begin
            state_nxt_s = ST_IDLE;
            gnt_nxt_s   = NCH_ZERO;
            vld_nxt_s   = 1'b0;
          end
        end else begin
          vld_nxt_s = 1'b1;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        gnt_nxt_s   = NCH_ZERO;
        vld_nxt_s   = 1'b0;
      end
    endcase
  end

  // State, pointer and output registers; reset drops any outstanding grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      ptr_r   <= SEL_ZERO;
      sel_r   <= SEL_ZERO;
      gnt_r   <= NCH_ZERO;
      vld_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ptr_r   <= ptr_nxt_s;
      sel_r   <= sel_nxt_s;
      gnt_r   <= gnt_nxt_s;
      vld_r   <= vld_nxt_s;
    end
  end

  assign sel_out = sel_r;
  assign gnt_out = gnt_r;
  assign vld_out = vld_r;

endmodule

// File: tb/tb_rr_sel_arb.sv
// Self-checking bench for rr_sel_arb: directed scenarios followed by random
// traffic, every cycle compared against a behavioural round-robin model.
module tb_rr_sel_arb;

  localparam int SW  = 4;
  localparam int NCH = 16;

  logic           clk;
  logic           rst;
  logic [NCH-1:0] req_in;
  logic           ack_in;
  logic [SW-1:0]  sel_out;
  logic [NCH-1:0] gnt_out;
  logic           vld_out;

  int checks;
  int errors;

  // Reference model state
  bit m_busy;
  int m_sel;
  int m_ptr;

  rr_sel_arb #(.SEL_WIDTH(SW)) dut (
    .clk     (clk),
    .rst     (rst),
    .req_in  (req_in),
    .ack_in  (ack_in),
    .sel_out (sel_out),
    .gnt_out (gnt_out),
    .vld_out (vld_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // First requesting channel scanning start, start+1, ... modulo NCH; -1 if none.
  function automatic int search(input logic [NCH-1:0] r, input int start);
    for (int k = 0; k < NCH; k++) begin
      if (r[(start + k) % NCH]) return (start + k) % NCH;
    end
    return -1;
  endfunction

  task automatic model_edge();
    int s;
    if (rst) begin
      m_busy = 1'b0;
      m_sel  = 0;
      m_ptr  = 0;
    end else if (!m_busy) begin
      s = search(req_in, m_ptr);
      if (s >= 0) begin
        m_sel  = s;
        m_busy = 1'b1;
      end
    end else if (ack_in) begin
      m_ptr = (m_sel + 1) % NCH;
      s = search(req_in, m_ptr);
      if (s >= 0) m_sel = s;
      else        m_busy = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: advance the model with the pre-edge inputs, then compare outputs.
  task automatic step();
    logic [NCH-1:0] e_gnt;
    @(posedge clk);
    model_edge();
    #1;
    e_gnt = m_busy ? (16'h0001 << m_sel) : 16'h0000;
    chk("sel", 32'(sel_out), 32'(m_sel));
    chk("gnt", 32'(gnt_out), 32'(e_gnt));
    chk("vld", 32'(vld_out), 32'(m_busy));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int exp_seq[6];
    checks = 0;
    errors = 0;
    m_busy = 1'b0;
    m_sel  = 0;
    m_ptr  = 0;
    rst    = 1'b1;
    req_in = 16'hFFFF;
    ack_in = 1'b0;

    // Reset held 3 cycles with all channels requesting
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_vld", 32'(vld_out), 32'd0);
      chk("rst_gnt", 32'(gnt_out), 32'd0);
    end
    rst = 1'b0;
    step();
    chk("rel_vld", 32'(vld_out), 32'd1);
    chk("rel_sel", 32'(sel_out), 32'd0);
    ack_in = 1'b1;
    req_in = 16'h0000;
    step();
    chk("drain_vld", 32'(vld_out), 32'd0);

    // Single requester held four cycles, then acked while request drops
    ack_in = 1'b0;
    req_in = 16'h0020;
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("single_sel", 32'(sel_out), 32'd5);
      chk("single_gnt", 32'(gnt_out), 32'h0020);
    end
    ack_in = 1'b1;
    req_in = 16'h0000;
    step();
    chk("single_done", 32'(vld_out), 32'd0);
    // Ack while idle is ignored
    step();
    chk("idle_ack", 32'(vld_out), 32'd0);

    // Full rotation with ack every cycle: 0..15,0 with no bubbles
    do_reset();
    ack_in = 1'b0;
    req_in = 16'hFFFF;
    step();
    chk("rot_first", 32'(sel_out), 32'd0);
    ack_in = 1'b1;
    for (int i = 1; i <= NCH; i++) begin
      step();
      chk("rot_sel", 32'(sel_out), 32'(i % NCH));
      chk("rot_vld", 32'(vld_out), 32'd1);
    end

    // Sparse wrap-around 0,1,15,0,1,15
    do_reset();
    ack_in = 1'b0;
    req_in = 16'h8003;
    exp_seq = '{0, 1, 15, 0, 1, 15};
    step();
    chk("wrap_sel", 32'(sel_out), 32'(exp_seq[0]));
    ack_in = 1'b1;
    for (int i = 1; i < 6; i++) begin
      step();
      chk("wrap_sel", 32'(sel_out), 32'(exp_seq[i]));
    end

    // Sticky grant on channel 3 after its request drops
    do_reset();
    ack_in = 1'b0;
    req_in = 16'h0008;
    step();
    req_in = 16'h0107;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("sticky_sel", 32'(sel_out), 32'd3);
      chk("sticky_vld", 32'(vld_out), 32'd1);
    end
    ack_in = 1'b1;
    step();
    chk("sticky_next", 32'(sel_out), 32'd8);

    // Reset mid-transfer on channel 9, then re-grant one cycle after release
    do_reset();
    ack_in = 1'b0;
    req_in = 16'h0200;
    step();
    step();
    chk("mid_busy", 32'(sel_out), 32'd9);
    rst = 1'b1;
    step();
    chk("mid_rst_sel", 32'(sel_out), 32'd0);
    chk("mid_rst_vld", 32'(vld_out), 32'd0);
    rst = 1'b0;
    step();
    chk("mid_regrant", 32'(gnt_out), 32'h0200);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      rst    = ($urandom_range(0, 79) == 0);
      ack_in = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 3))
        0:       req_in = 16'h0000;
        1:       req_in = 16'(1 << $urandom_range(0, NCH - 1));
        2:       req_in = 16'($urandom) & 16'($urandom);
        default: req_in = 16'($urandom);
      endcase
      step();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_sel_arb.md
Name: rr_sel_arb

Overview:
- Round-robin arbiter that sits directly upstream of the parameterized select-indexed mux.
- Selects one of 2**SEL_WIDTH requesting channels and drives the mux select with a registered binary index.
- Holds each grant until the downstream consumer acknowledges the word, then moves to the next requester in fair rotation.
- Also supplies one-hot grant lines so each source can see when its data is being taken.

Parameters:
- SEL_WIDTH, 4, width of the select index; channel count is NCH = 2**SEL_WIDTH.
- NCH, 2**SEL_WIDTH, local derived constant; not overridable.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- req_in  input  NCH  per-channel request; bit i high means channel i holds valid data on its mux slice.
- ack_in  input  1  downstream accepted the currently selected word this cycle; only meaningful while vld_out=1.
- sel_out  output  SEL_WIDTH  registered binary index of the granted channel; connects to the mux sel_in.
- gnt_out  output  NCH  registered one-hot grant; equals 1<<sel_out while vld_out=1, otherwise all zero.
- vld_out  output  1  registered; mux output is valid and awaiting ack_in.

Behaviour:
- Reset values: on rst=1 at a clock edge, sel_out=0, gnt_out=0, vld_out=0, state=IDLE, internal rotation pointer ptr=0. rst takes priority over every other input.
- State IDLE: vld_out=0.
  - If req_in != 0, search channels in the order ptr, ptr+1, …, ptr+NCH-1 (mod NCH) and pick the first set bit k.
  - Next edge: sel_out=k, gnt_out=1<<k, vld_out=1, state=BUSY.
  - Latency from req_in rising to vld_out is exactly 1 cycle.
- State BUSY: vld_out=1. sel_out and gnt_out are held stable until ack_in=1.
  - The grant is sticky: if req_in[sel_out] drops before ack_in, the grant and vld_out remain unchanged.
- ack_in=1 in BUSY: ptr <= sel_out+1 (mod NCH, natural wrap in SEL_WIDTH bits).
  - The same cycle, search req_in starting from sel_out+1.
  - If any bit is set, grant it on the next edge and stay in BUSY. This gives back-to-back transfers with no idle bubble.
  - The just-served channel is lowest priority and is re-granted only if it is the sole requester.
  - If req_in == 0, go to IDLE with vld_out=0 and gnt_out=0. sel_out keeps its last value.
- ack_in while in IDLE is ignored.
- Fairness: a continuously requesting channel is granted within at most NCH-1 other grants.
- Wrap-around: with sel_out = NCH-1, the next search starts at channel 0.
- Reset mid-transfer: an outstanding grant is dropped without acknowledgement. The source must re-present its data; no ack is implied.
- There is no combinational path from inputs to outputs; all outputs come straight from flops.

Decomposition:
- Shared package (mux_pkg):
  - localparam function for NCH from SEL_WIDTH.
  - State encoding constants ST_IDLE=1'b0, ST_BUSY=1'b1.
- One natural sub-module, rr_prio_find (combinational):
  - Takes the NCH-bit request vector and a SEL_WIDTH start index.
  - Returns found flag and binary index of the first set bit at or after start, wrapping.
  - Implemented by double-width concatenation and rotate.
  - Reused for both the IDLE search and the ack-time search.

Test Plan:
- Reset: hold rst=1 for 3 cycles with req_in=16'hFFFF -> sel_out=0, gnt_out=0, vld_out=0 throughout. First cycle after release: vld_out=1, sel_out=0.
- Single requester: req_in=16'h0020, ack_in pulsed 4 cycles after vld_out -> sel_out=5, gnt_out=16'h0020 held stable all 4 cycles; vld_out=0 the cycle after ack.
- Rotation: req_in=16'hFFFF, ack_in=1 every cycle -> sel_out sequence 0,1,2,…,15,0 with vld_out continuously 1 and no bubbles.
- Sparse wrap: req_in=16'h8003, ack every cycle -> sel_out sequence 0,1,15,0,1,15.
- Sticky grant: grant channel 3, drop req_in[3] before ack, others requesting -> sel_out stays 3 until ack_in, then advances to the next set bit above 3.
- Mid-transfer reset: while BUSY on channel 9, assert rst for 1 cycle -> all outputs return to 0. With req_in=16'h0200 still asserted, channel 9 is re-granted 1 cycle after rst deasserts.
